// File: rtl/com_csr_csr2ahbl.sv
// CSR-request to AHB-Lite single-beat master bridge, one transfer outstanding.
// Latency: accept N, address N+1, data N+2, response N+3 (+1 per wait state); req_rdy only in IDLE.
module com_csr_csr2ahbl #(
  parameter int                AW_CSR   = 20,
  parameter int                AW_AHB   = 32,
  parameter int                DW       = 32,
  parameter logic [AW_AHB-1:0] AHB_BASE = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              csr_req_vld,
  output logic              csr_req_rdy,
  input  logic              csr_req_wr,
  input  logic [AW_CSR-1:0] csr_req_addr,
  input  logic [DW-1:0]     csr_req_wdata,
  output logic              csr_rsp_vld,
  input  logic              csr_rsp_rdy,
  output logic [DW-1:0]     csr_rsp_rdata,
  output logic              csr_rsp_err,
  output logic              busy,
  output logic [AW_AHB-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DW-1:0]     HWDATA,
  input  logic [DW-1:0]     HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RSP} state_e;

  state_e            state_q;
  logic              wr_q;
  logic [AW_CSR-1:0] addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rdata_q;
  logic              err_q;
  logic              unused_addr_lsb;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (csr_req_vld) begin
          wr_q    <= csr_req_wr;
          addr_q  <= csr_req_addr;
          wdata_q <= csr_req_wdata;
          state_q <= ADDR;
        end
        ADDR: if (HREADY) state_q <= DATA;
        // HREADY low here also covers the first cycle of a two-cycle ERROR
        DATA: if (HREADY) begin
          err_q   <= HRESP;
          rdata_q <= (!wr_q && !HRESP) ? HRDATA : '0;
          state_q <= RSP;
        end
        RSP: if (csr_rsp_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign csr_req_rdy   = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign csr_rsp_vld   = (state_q == RSP);
  assign csr_rsp_rdata = rdata_q;
  assign csr_rsp_err   = err_q;

  // Word-aligned: the byte-lane bits never reach the bus
  assign HADDR  = AHB_BASE | AW_AHB'({addr_q[AW_CSR-1:2], 2'b00});
  assign HTRANS = (state_q == ADDR) ? 2'b10 : 2'b00;
  assign HWRITE = wr_q;
  assign HWDATA = wdata_q;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;

  assign unused_addr_lsb = ^addr_q[1:0];

endmodule

// File: doc/com_csr_csr2ahbl.md
# com_csr_csr2ahbl

AHB-Lite master bridge that accepts single CSR read/write requests and issues each as one single-beat AHB-Lite transfer. It is the initiator-side counterpart of the AHB-to-CSR slave bridge: it lets a CSR-domain agent, such as a debug or config sequencer, reach memory-mapped AHB peripherals. The bridge is strictly non-pipelined with one outstanding transfer, and it returns read data and error status on a CSR response handshake.

## Interface
- AW_CSR, 20: CSR byte-address width.
- AW_AHB, 32: AHB address width; must satisfy AW_AHB ≥ AW_CSR.
- DW, 32: data width on both sides; only 32 is supported.
- AHB_BASE, 32'h0000_0000: OR-ed into HADDR; its low AW_CSR bits must be zero.

- clk  in  1  sole clock; drives the CSR side and AHB HCLK.
- clear  in  1  reset; synchronous, active-high.
- csr_req_vld  in  1  request valid.
- csr_req_rdy  out  1  request ready; a request transfers when vld&rdy.
- csr_req_wr  in  1  1 = write, 0 = read.
- csr_req_addr  in  AW_CSR  byte address.
- csr_req_wdata  in  DW  write data.
- csr_rsp_vld  out  1  response valid.
- csr_rsp_rdy  in  1  response accept.
- csr_rsp_rdata  out  DW  read data; 0 for writes.
- csr_rsp_err  out  1  the AHB slave returned ERROR.
- busy  out  1  high in every state except IDLE.
- HADDR  out  AW_AHB; HTRANS out 2; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HWDATA out DW.
- HRDATA  in  DW; HREADY  in  1; HRESP  in  1 (0 = OKAY, 1 = ERROR).

## Operation
- FSM states: IDLE, ADDR, DATA, RSP. State is encoded in registers; all outputs are decoded from the state and from registers.
- **IDLE**
  - csr_req_rdy=1.
  - On csr_req_vld, capture wr, addr and wdata into holding registers, then go to ADDR.
- **ADDR**
  - HTRANS=2'b10 (NONSEQ).
  - HADDR = AHB_BASE | zero-extended {addr_r[AW_CSR-1:2], 2'b00}; the low 2 address bits are always forced to 0.
  - HWRITE=wr_r.
  - When HREADY=1, go to DATA. When HREADY=0, hold every address-phase signal stable and stay in ADDR.
- **DATA**
  - HTRANS=2'b00 (IDLE).
  - HWDATA=wdata_r, held for the whole data phase.
  - When HREADY=1:
    - latch err_r=HRESP;
    - latch rdata_r = (!wr_r && !HRESP) ? HRDATA : 0;
    - go to RSP.
  - When HREADY=0, stay in DATA. This covers wait states and the first cycle of a two-cycle ERROR response (HRESP=1, HREADY=0).
- **RSP**
  - csr_rsp_vld=1, csr_rsp_rdata=rdata_r, csr_rsp_err=err_r.
  - On csr_rsp_rdy, go to IDLE.
- Fixed outputs in every state: HSIZE=3'b010 (word), HBURST=3'b000 (SINGLE), HPROT=4'b0011 (non-cacheable, non-bufferable, privileged data).
- HTRANS is NONSEQ only in ADDR. BUSY and SEQ are never issued.
- HWDATA outside DATA holds the last wdata_r value; slaves must not sample it.
- csr_req_rdy=0 in ADDR, DATA and RSP. A new request is accepted only in IDLE, so it never overlaps the previous response.
- A write that receives an ERROR response still completes on the CSR side, with csr_rsp_err=1 and rdata=0.

## Timing
- **Values during and after clear**, applied on the clock edge where clear=1:
  - state=IDLE;
  - HTRANS=2'b00, HADDR=AHB_BASE, HWRITE=0, HWDATA=0;
  - csr_rsp_vld=0, csr_rsp_rdata=0, csr_rsp_err=0;
  - busy=0, csr_req_rdy=1 (IDLE decode) in the cycle after clear.
- **Latency with zero wait states:**
  - request accepted in cycle N;
  - address phase in N+1;
  - data phase in N+2;
  - csr_rsp_vld in N+3.
- Each AHB wait state adds exactly one cycle, in either the address phase or the data phase.
- Maximum issue rate is one transfer per 4 cycles when csr_rsp_rdy is tied to 1.
- csr_rsp_vld, once asserted, stays high with stable rdata and err until accepted.
- csr_req_vld deasserted in IDLE causes no AHB activity; HTRANS stays IDLE.
- **clear mid-transfer** (in ADDR or DATA): the FSM returns to IDLE immediately. clear must be asserted together with the AHB reset so the bus is not left with an orphaned data phase; a pending response is discarded.
- clear takes priority over every other state transition.

## Test plan
- **Zero-wait write:** req wr=1, addr=0x00104, wdata=0xA5A5_0001, HREADY=1 → HADDR=0x0000_0104 with NONSEQ in cycle N+1, HWDATA=0xA5A5_0001 in N+2, rsp_vld in N+3 with err=0.
- **Read with 2 data wait states:** addr=0x00010, slave returns 0x1234_5678 on the third data-phase cycle → rsp_vld at N+5, rdata=0x1234_5678, err=0.
- **ERROR response on read:** 2-cycle ERROR (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) → rsp err=1, rdata=0; the next request is issued normally.
- **Address-phase stall:** HREADY=0 for 3 cycles during ADDR → HADDR, HTRANS and HWRITE are stable throughout; exactly one NONSEQ is accepted.
- **Backpressure:** csr_rsp_rdy=0 for 5 cycles with csr_req_vld held at 1 → rsp stable, req_rdy=0, no new NONSEQ; after acceptance, IDLE and then the next request is accepted.
- **clear in DATA:** assert clear for 1 cycle during the data phase → next cycle IDLE, HTRANS=0, rsp_vld=0, busy=0.
